fp16_acc_ctrl: RTL and testbench
================================

Name: fp16_acc_ctrl

Overview:
Sequential accumulation controller that sits upstream of the shared FP16/INT16 adder stage (mode 1 = FP16, mode 0 = 16-bit integer) and consumes the adder's result. It accepts a stream of operands over valid/ready, drives the adder with {accumulator, operand}, and writes back the sum. After the programmed element count it presents the final sum over valid/ready. It is used to build dot-product/MAC reductions.

Parameters:
LEN_W, 8, width of element-count field; a maximum of 2^LEN_W-1 elements per job.
ADD_LAT, 0, register stages inside the external adder (0 = combinational, 1 = pipelined build).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  job start pulse; sampled only in IDLE
mode_i  in  1  job mode (1 = FP16, 0 = INT16); latched on start
len_i  in  LEN_W  number of elements in the job; latched on start
in_valid  in  1  operand valid
in_data  in  16  operand
in_ready  out  1  controller can take an operand
add_mode  out  1  mode to adder (latched job mode)
add_a  out  16  adder operand A (accumulator register)
add_b  out  16  adder operand B (registered operand)
add_valid  out  1  one-cycle strobe on the first cycle of each adder operation
add_c  in  16  adder result
out_valid  out  1  final sum valid
out_data  out  16  final sum
out_ready  in  1  downstream accepts sum
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE; acc_q, opnd_q, cnt_q, lat_q, mode_q, first_q all cleared. All outputs 0: in_ready, add_valid, out_valid, busy, add_mode, add_a, add_b, out_data.
- add_a = acc_q, add_b = opnd_q, add_mode = mode_q, out_data = acc_q. All are registered values with no combinational path from inputs.
- The FSM has four states: IDLE, ACCUM, ADD and DONE.
- IDLE:
  - When start_i is high, latch mode_i and len_i, set acc_q = 16'h0000 and first_q = 1.
  - If len_i == 0, go to DONE, which yields out_data 0. Otherwise go to ACCUM.
- ACCUM: in_ready = 1. On in_valid && in_ready, cnt_q decrements and one of the following applies:
  - If first_q is set: acc_q <= in_data (bypass; the adder never sees the +0 accumulator), and first_q clears.
  - Else if mode_q == 1 and in_data[14:0] == 0 (±0.0): the operand is skipped and acc_q is unchanged.
  - Else: opnd_q <= in_data, lat_q <= ADD_LAT, go to ADD.
  - When the decremented count reaches 0 on a bypass or skip, go directly to DONE.
- ADD:
  - in_ready = 0; add_valid = 1 on the first ADD cycle only.
  - Wait while lat_q != 0, decrementing it each cycle.
  - On the cycle lat_q == 0: acc_q <= add_c, then go to DONE if cnt_q == 0, else back to ACCUM.
  - Occupancy is ADD_LAT+1 cycles, so steady-state throughput is one operand per ADD_LAT+2 cycles.
- DONE: out_valid = 1 and stays high, with out_data stable, until out_ready is high. On that handshake go to IDLE.
- start_i outside IDLE is ignored. in_valid outside ACCUM is ignored (no handshake).
- INT mode wraps modulo 2^16. No overflow flag is produced. FP16 special values are not interpreted beyond the zero skip.
- Latency from the last operand handshake to out_valid:
  - 1 cycle when the last operand is bypassed or skipped.
  - ADD_LAT+2 cycles when the last operand goes through the adder.
- Reset asserted mid-job aborts the job immediately and discards the partial sum. Operands accepted before reset are not replayed.

Decomposition:
- Shared package fp16_pkg holds:
  - state encoding constants for IDLE/ACCUM/ADD/DONE;
  - MODE_FP16 = 1, MODE_INT = 0;
  - FP16_POS_ZERO = 16'h0000;
  - the sign/exponent/mantissa field ranges [15], [14:10], [9:0].
- No sub-module. The FSM plus counters form a single module, and the adder stays external so both ADD_LAT builds can share the controller.

Test Plan:
- FP16, len 2, operands 3C00, 4000 → one add_valid with add_a = 3C00 and add_b = 4000; out_data = 4200 (3.0).
- FP16, len 4, four × 3C00 → three add_valid strobes; out_data = 4400 (4.0); with ADD_LAT = 1, out_valid arrives 3 cycles after the last handshake.
- FP16, len 4, operands 3C00, 0000, 8000, 3C00 → exactly one add_valid; out_data = 4000.
- INT, len 3, operands 00FF, 0001, FFFF → out_data = 00FF (wrap); add_mode = 0 throughout.
- len 0 start → out_valid next cycle with out_data = 0000 and no in_ready. Hold out_ready low 5 cycles → out_valid and out_data stay stable, and a start_i pulse during DONE is ignored.
- Assert rst_n low in the middle of ADD during a len-4 job → all outputs are 0 immediately and the state is IDLE. A new len-1 job with 4200 then returns 4200.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16/INT16 accumulation controller: FSM states,
// adder mode encodings and the FP16 bit-field layout.
package fp16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ADD   = 2'd2,
        ST_DONE  = 2'd3
    } acc_state_t;

    localparam logic MODE_FP16 = 1'b1;
    localparam logic MODE_INT  = 1'b0;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

    // sign [15], exponent [14:10], mantissa [9:0]
    typedef struct packed {
        logic       sign;
        logic [4:0] exponent;
        logic [9:0] mantissa;
    } fp16_t;

    // Both +0.0 and -0.0 count as zero; only the sign may be set.
    function automatic logic fp16_is_zero(input logic [15:0] value);
        fp16_t f;
        f = value;
        return (f.exponent == 5'd0) && (f.mantissa == 10'd0);
    endfunction

endpackage

// File: rtl/fp16_acc_ctrl.sv
// Accumulation controller feeding an external FP16/INT16 adder: streams operands
// in, folds them into an accumulator through the adder, and hands out the sum.
module fp16_acc_ctrl
    import fp16_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int ADD_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             add_mode,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             add_valid,
    input  logic [15:0]      add_c,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int LAT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ADD_LAT);

    acc_state_t       state_q;
    logic [15:0]      acc_q;
    logic [15:0]      opnd_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LAT_W-1:0] lat_q;
    logic             mode_q;
    logic             first_q;

    logic             in_ready_q;
    logic             add_valid_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [LEN_W-1:0] cnt_dec;
    logic             accept;
    logic             skip_op;
    logic             last_elem;

    assign cnt_dec   = cnt_q - 1'b1;
    assign accept    = in_valid && in_ready_q;
    assign skip_op   = (mode_q == MODE_FP16) && fp16_is_zero(in_data);
    assign last_elem = (cnt_dec == '0);

    // Every output is a flop or a direct view of one, so nothing combinational
    // leaks from the inputs to the adder or the downstream consumer.
    assign in_ready  = in_ready_q;
    assign add_valid = add_valid_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign add_mode  = mode_q;
    assign add_a     = acc_q;
    assign add_b     = opnd_q;
    assign out_data  = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= FP16_POS_ZERO;
            opnd_q      <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            mode_q      <= MODE_INT;
            first_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            add_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            add_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q  <= mode_i;
                        cnt_q   <= len_i;
                        acc_q   <= FP16_POS_ZERO;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                        if (len_i == '0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ACCUM;
                            in_ready_q <= 1'b1;
                        end
                    end
                end

                ST_ACCUM: begin
                    if (accept) begin
                        cnt_q <= cnt_dec;
                        // The first operand lands directly in the accumulator and
                        // FP16 zeros are dropped; neither needs an adder pass.
                        if (first_q || skip_op) begin
                            if (first_q) begin
                                acc_q   <= in_data;
                                first_q <= 1'b0;
                            end
                            if (last_elem) begin
                                state_q     <= ST_DONE;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end
                        end else begin
                            opnd_q      <= in_data;
                            lat_q       <= LAT_INIT;
                            state_q     <= ST_ADD;
                            in_ready_q  <= 1'b0;
                            add_valid_q <= 1'b1;
                        end
                    end
                end

                ST_ADD: begin
                    if (lat_q != '0) begin
                        lat_q <= lat_q - 1'b1;
                    end else begin
                        acc_q <= add_c;
                        if (cnt_q == '0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ACCUM;
                            in_ready_q <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_acc_ctrl.sv
// Self-checking bench for fp16_acc_ctrl with a pipelined adder model; directed
// vectors, hand-written corner sequences and random jobs against a fold model.
module tb_fp16_acc_ctrl;

    localparam int LEN_W   = 8;
    localparam int ADD_LAT = 1;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic             mode_i;
    logic [LEN_W-1:0] len_i;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             add_mode;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic             add_valid;
    logic [15:0]      add_c;
    logic             out_valid;
    logic [15:0]      out_data;
    logic             out_ready;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    fp16_acc_ctrl #(.LEN_W(LEN_W), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .len_i(len_i),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_mode(add_mode), .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
        .add_c(add_c), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FP16 helpers restricted to exact integers (|v| < 2048), enough for the bench.
    function automatic int half_to_int(input logic [15:0] h);
        int e;
        int mag;
        e = int'(h[14:10]);
        if (e < 15 || e > 25) return 0;
        mag = (1024 + int'(h[9:0])) >> (25 - e);
        return h[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] int_to_half(input int v);
        int m;
        int e;
        logic [15:0] r;
        m = (v < 0) ? -v : v;
        if (m == 0) return 16'h0000;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        r[15]    = (v < 0);
        r[14:10] = 5'(e + 15);
        r[9:0]   = 10'((m << (10 - e)) & 32'h3FF);
        return r;
    endfunction

    function automatic logic [15:0] adder_model(input logic [15:0] a, input logic [15:0] b,
                                                input logic m);
        if (m) return int_to_half(half_to_int(a) + half_to_int(b));
        return a + b;
    endfunction

    logic [15:0] add_c_q;
    always @(posedge clk) add_c_q <= adder_model(add_a, add_b, add_mode);
    assign add_c = (ADD_LAT == 0) ? adder_model(add_a, add_b, add_mode) : add_c_q;

    // Adder traffic monitor, sampled on the falling edge.
    int          strobe_total = 0;
    int          mode_errs    = 0;
    logic        job_mode     = 1'b0;
    logic [15:0] strobe_a [4096];
    logic [15:0] strobe_b [4096];
    always @(negedge clk) begin
        if (add_valid) begin
            strobe_a[strobe_total % 4096] = add_a;
            strobe_b[strobe_total % 4096] = add_b;
            strobe_total = strobe_total + 1;
        end
        if (busy && add_mode !== job_mode) mode_errs = mode_errs + 1;
    end

    logic [15:0] job_ops [64];

    typedef struct {
        logic        mode;
        int          len;
        logic [15:0] ops [4];
        logic [15:0] exp_data;
        int          exp_adds;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        int          exp_lat;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: fold the operand list the way the job is defined, independent of timing.
    task automatic model_job(input logic mode, input int len, output logic [15:0] sum,
                             output int adds, output int lat);
        sum  = 16'h0000;
        adds = 0;
        lat  = 1;
        for (int i = 0; i < len; i++) begin
            if (i == 0) begin
                sum = job_ops[i];
                lat = 1;
            end else if (mode && job_ops[i][14:0] == 15'd0) begin
                lat = 1;
            end else begin
                sum  = adder_model(sum, job_ops[i], mode);
                adds = adds + 1;
                lat  = ADD_LAT + 2;
            end
        end
    endtask

    // Runs one job from start pulse to result handshake; starts and ends on a negedge.
    task automatic apply_stimulus(input logic mode, input int len, input int hold,
                                  input int max_gap, input string tag,
                                  output logic [15:0] data, output int adds,
                                  output int lat, output logic [15:0] first_a,
                                  output logic [15:0] first_b);
        int snap;
        int guard;
        snap     = strobe_total;
        job_mode = mode;
        start_i  = 1'b1;
        mode_i   = mode;
        len_i    = LEN_W'(len);
        @(negedge clk);
        start_i  = 1'b0;
        lat      = 1;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = job_ops[i];
            guard    = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                check_output({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check_output({tag, " out_valid timeout"}, 32'(out_valid), 32'd1);
        data = out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_output({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check_output({tag, " hold data"}, 32'(out_data), 32'(data));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output({tag, " idle after"}, {30'd0, busy, out_valid}, 32'd0);
        adds    = strobe_total - snap;
        first_a = strobe_a[snap % 4096];
        first_b = strobe_b[snap % 4096];
    endtask

    vec_t        vecs [4];
    logic [15:0] got_data;
    logic [15:0] exp_data;
    logic [15:0] fa;
    logic [15:0] fb;
    int          got_adds;
    int          got_lat;
    int          exp_adds;
    int          exp_lat;
    int          guard;
    int          snap_errs;

    initial begin
        rst_n     = 1'b0;
        start_i   = 1'b0;
        mode_i    = 1'b0;
        len_i     = '0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;

        vecs[0] = '{mode: 1'b1, len: 2, ops: '{16'h3C00, 16'h4000, 16'h0, 16'h0},
                    exp_data: 16'h4200, exp_adds: 1, exp_a: 16'h3C00, exp_b: 16'h4000, exp_lat: 3};
        vecs[1] = '{mode: 1'b1, len: 4, ops: '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00},
                    exp_data: 16'h4400, exp_adds: 3, exp_a: 16'h3C00, exp_b: 16'h3C00, exp_lat: 3};
        vecs[2] = '{mode: 1'b1, len: 4, ops: '{16'h3C00, 16'h0000, 16'h8000, 16'h3C00},
                    exp_data: 16'h4000, exp_adds: 1, exp_a: 16'h3C00, exp_b: 16'h3C00, exp_lat: 3};
        vecs[3] = '{mode: 1'b0, len: 3, ops: '{16'h00FF, 16'h0001, 16'hFFFF, 16'h0},
                    exp_data: 16'h00FF, exp_adds: 2, exp_a: 16'h00FF, exp_b: 16'h0001, exp_lat: 3};

        repeat (2) @(negedge clk);
        check_output("reset outputs",
                     {6'd0, in_ready, add_valid, out_valid, busy, add_mode, add_a, 5'd0},
                     32'd0);
        check_output("reset data", {add_b, out_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) job_ops[k] = vecs[v].ops[k];
            snap_errs = mode_errs;
            apply_stimulus(vecs[v].mode, vecs[v].len, 1, 0, $sformatf("vec%0d", v),
                           got_data, got_adds, got_lat, fa, fb);
            check_output($sformatf("vec%0d data", v), 32'(got_data), 32'(vecs[v].exp_data));
            check_output($sformatf("vec%0d adds", v), 32'(got_adds), 32'(vecs[v].exp_adds));
            check_output($sformatf("vec%0d latency", v), 32'(got_lat), 32'(vecs[v].exp_lat));
            check_output($sformatf("vec%0d add_a", v), 32'(fa), 32'(vecs[v].exp_a));
            check_output($sformatf("vec%0d add_b", v), 32'(fb), 32'(vecs[v].exp_b));
            check_output($sformatf("vec%0d add_mode", v), 32'(mode_errs - snap_errs), 32'd0);
        end

        // Zero-length job: result next cycle, held under backpressure, start ignored.
        job_mode = 1'b1;
        start_i  = 1'b1;
        mode_i   = 1'b1;
        len_i    = '0;
        @(negedge clk);
        start_i = 1'b0;
        check_output("len0 out_valid", 32'(out_valid), 32'd1);
        check_output("len0 out_data", 32'(out_data), 32'h0000);
        check_output("len0 in_ready", 32'(in_ready), 32'd0);
        for (int h = 0; h < 5; h++) begin
            start_i = (h == 2);
            len_i   = LEN_W'(3);
            @(negedge clk);
            check_output("len0 hold", {15'd0, out_valid, out_data}, 32'h0001_0000);
            check_output("len0 no in_ready", 32'(in_ready), 32'd0);
        end
        start_i   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_output("len0 back to idle", {29'd0, busy, out_valid, in_ready}, 32'd0);

        // Reset in the middle of an add aborts the job.
        for (int k = 0; k < 4; k++) job_ops[k] = 16'h3C00;
        job_mode = 1'b1;
        start_i  = 1'b1;
        mode_i   = 1'b1;
        len_i    = LEN_W'(4);
        @(negedge clk);
        start_i  = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        guard    = 0;
        while (!add_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_output("abort reached ADD", 32'(add_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("abort outputs",
                     {6'd0, in_ready, add_valid, out_valid, busy, add_mode, add_a, 5'd0},
                     32'd0);
        check_output("abort data", {add_b, out_data}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        job_ops[0] = 16'h4200;
        apply_stimulus(1'b1, 1, 0, 0, "post-reset", got_data, got_adds, got_lat, fa, fb);
        check_output("post-reset data", 32'(got_data), 32'h4200);
        check_output("post-reset adds", 32'(got_adds), 32'd0);
        check_output("post-reset latency", 32'(got_lat), 32'd1);

        // Random jobs against the fold model.
        for (int j = 0; j < 30; j++) begin
            logic m;
            int   len;
            m   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if (m) begin
                    int s;
                    s = $urandom_range(0, 16) - 8;
                    if (s == 0) job_ops[i] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
                    else        job_ops[i] = int_to_half(s);
                end else begin
                    job_ops[i] = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
                end
            end
            model_job(m, len, exp_data, exp_adds, exp_lat);
            snap_errs = mode_errs;
            apply_stimulus(m, len, $urandom_range(0, 3), 2, $sformatf("rnd%0d", j),
                           got_data, got_adds, got_lat, fa, fb);
            check_output($sformatf("rnd%0d data", j), 32'(got_data), 32'(exp_data));
            check_output($sformatf("rnd%0d adds", j), 32'(got_adds), 32'(exp_adds));
            check_output($sformatf("rnd%0d latency", j), 32'(got_lat), 32'(exp_lat));
            check_output($sformatf("rnd%0d add_mode", j), 32'(mode_errs - snap_errs), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
